mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Multi-cycle RV32M multiply/divide unit downstream of the single-cycle datapath. It replaces that datapath's combinational `*`, `/` and `%` operators.
- Datapath hands over two register operands and the M-extension funct3 with a start pulse. The unit iterates one bit per cycle and returns a 32-bit result with a one-cycle done pulse; the datapath stalls PC/writeback until then.
- Implements full RISC-V edge-case semantics: divide-by-zero and signed overflow.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- SYS_clk  input  1  clock; all state updates on rising edge.
- SYS_reset  input  1  synchronous, active-high reset.
- MDU_start  input  1  request; sampled only when the unit is idle or in DONE.
- MDU_funct3  input  3  operation: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- MDU_operand_a  input  WIDTH  rs1 value (multiplicand / dividend).
- MDU_operand_b  input  WIDTH  rs2 value (multiplier / divisor).
- MDU_busy  output  1  high in PREP, CALC, FIX.
- MDU_done  output  1  one-cycle pulse; MDU_result valid this cycle.
- MDU_result  output  WIDTH  result; holds until next accepted start.

Behaviour:
- Reset: state IDLE, MDU_busy=0, MDU_done=0, MDU_result=0, counter=0, all internal registers 0.
- Reset mid-operation aborts immediately; no done pulse is issued.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: on MDU_start=1, latch funct3, a, b and go to PREP.
- PREP (1 cycle):
  - Record result sign and replace operands with magnitudes.
  - a is signed for mulh, mulhsu, div, rem. b is signed for mulh, div, rem.
  - mul computes the unsigned product (low half is sign-independent).
  - Load counter=WIDTH-1.
  - Special divide cases skip CALC and go straight to DONE with the special result:
    - b==0: div/divu give all-ones; rem/remu give a.
    - div/rem with a=0x80000000 and b=0xFFFFFFFF: div gives 0x80000000, rem gives 0.
  - Otherwise go to CALC.
- CALC (exactly WIDTH cycles):
  - Multiply: shift-add into a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first; remainder register is WIDTH+1 bits.
  - Counter decrements each cycle; at counter==0 go to FIX.
- FIX (1 cycle):
  - Apply two's-complement negation if the recorded sign is negative. Quotient sign is a XOR b; remainder sign follows a; product sign is a XOR b.
  - Select product[WIDTH-1:0] for mul and product[2W-1:W] for mulh/mulhsu/mulhu.
  - Register the result into MDU_result.
- DONE (1 cycle): MDU_done=1, MDU_busy=0.
  - If MDU_start=1 in this cycle, the new request is latched and the unit goes to PREP (back-to-back).
  - Otherwise it returns to IDLE.
- Latency: start sampled in cycle T gives MDU_done in cycle T+WIDTH+3 (T+35); special cases give done in T+2.
- MDU_start while busy is ignored; inputs need only be valid in the start cycle.
- Result register is only written in FIX or on a PREP special case, never otherwise.

Test Plan:
- mul a=7, b=0xFFFFFFFD (-3), start at T -> done at T+35, result 0xFFFFFFEB; busy high T+1..T+34.
- mulh a=b=0x80000000 -> 0x40000000; mulhsu a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; mulhu same operands -> 0xFFFFFFFE.
- divu 100/7 -> 14; remu -> 2; rem a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFF; div same -> 0xFFFFFFFD; each done at T+35.
- div a=5, b=0 -> done T+2, 0xFFFFFFFF; remu a=5, b=0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0, done T+2.
- Start pulse during CALC with different operands -> ignored, original result returned at T+35. Start asserted in the DONE cycle -> second op accepted, its done 35 cycles later.
- SYS_reset asserted at T+10 of a divide -> next cycle busy=0, result=0, and no done pulse follows.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one bit per cycle,
// shift-add multiply and restoring divide with sign fix-up.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             MDU_start,
  input  logic [2:0]       MDU_funct3,
  input  logic [WIDTH-1:0] MDU_operand_a,
  input  logic [WIDTH-1:0] MDU_operand_b,
  output logic             MDU_busy,
  output logic             MDU_done,
  output logic [WIDTH-1:0] MDU_result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             neg_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             a_sgn, b_sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   fix_res;

  assign accept = MDU_start &&
    (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_q)
      3'b001: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010: a_sgn = 1'b1;
      3'b100: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      default: ;
    endcase
  end

  assign a_neg = a_sgn & a_q[WIDTH-1];
  assign b_neg = b_sgn & b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;

  // Divide corner cases resolve in PREP without iterating
  assign div_zero = op_q[2] && (b_q == '0);
  assign div_ovf  = op_q[2] && !op_q[0] &&
    (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op_q[1] ? a_q : '1;
    else if (div_ovf)
      special_res = op_q[1] ? '0 : a_q;
  end

  assign mul_sum = {1'b0, acc_hi} +
    (acc_lo[0] ? {1'b0, opnd} : '0);

  assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, opnd};
  assign rem_sub   = rem_shift[WIDTH-1:0] - opnd;

  always_comb begin
    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    if (op_q[2]) begin
      if (rem_ge) begin
        nxt_hi = rem_sub;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_shift[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  assign prod   = {acc_hi, acc_lo};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -acc_lo : acc_lo;
  assign rem_s  = neg_q ? -acc_hi : acc_hi;

  always_comb begin
    fix_res = '0;
    unique case (1'b1)
      op_q == 3'b000: fix_res = prod_s[WIDTH-1:0];
      op_q[2:1] == 2'b10: fix_res = quo_s;
      op_q[2:1] == 2'b11: fix_res = rem_s;
      default: fix_res = prod_s[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    MDU_busy = 1'b0;
    MDU_done = 1'b0;
    case (state_q)
      S_IDLE: if (MDU_start) state_d = S_PREP;
      S_PREP: begin
        MDU_busy = 1'b1;
        state_d  = special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        MDU_busy = 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        MDU_busy = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        MDU_done = 1'b1;
        state_d  = MDU_start ? S_PREP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q <= MDU_funct3;
        a_q  <= MDU_operand_a;
        b_q  <= MDU_operand_b;
      end
      case (state_q)
        S_PREP: begin
          cnt_q  <= CW'(WIDTH - 1);
          neg_q  <= (op_q[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
          acc_hi <= '0;
          // Divide iterates on the dividend, multiply on the multiplier
          acc_lo <= op_q[2] ? a_mag : b_mag;
          opnd   <= op_q[2] ? b_mag : a_mag;
          if (special) result_q <= special_res;
        end
        S_CALC: begin
          cnt_q  <= cnt_q - CW'(1);
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
        end
        S_FIX: result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign MDU_result = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed RV32M cases plus
// randomized ops checked against a plain-arithmetic model.
module tb_mdu_iterative;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        MDU_start;
  logic [2:0]  MDU_funct3;
  logic [31:0] MDU_operand_a;
  logic [31:0] MDU_operand_b;
  logic        MDU_busy;
  logic        MDU_done;
  logic [31:0] MDU_result;

  mdu_iterative #(.WIDTH(32)) dut (
    .SYS_clk      (SYS_clk),
    .SYS_reset    (SYS_reset),
    .MDU_start    (MDU_start),
    .MDU_funct3   (MDU_funct3),
    .MDU_operand_a(MDU_operand_a),
    .MDU_operand_b(MDU_operand_b),
    .MDU_busy     (MDU_busy),
    .MDU_done     (MDU_done),
    .MDU_result   (MDU_result)
  );

  always #5 SYS_clk = ~SYS_clk;

  int cyc = 0;
  always @(posedge SYS_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
    logic [2:0]  f;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_exp;

  function automatic logic [31:0] ref_mdu(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ub  = longint'({32'b0, b});
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb_);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb_);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(
    input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 ||
      (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge SYS_clk) begin
    if (!SYS_reset && MDU_done) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL spurious_done cyc=%0d got result=%h, required no done",
                 cyc, MDU_result);
      end else begin
        mon_e = sb.pop_front();
        if (MDU_result !== mon_e.res || cyc != mon_e.due) begin
          fails++;
          $display("FAIL op%0d_result got %h at cyc %0d, required %h at cyc %0d",
                   mon_e.f, MDU_result, cyc, mon_e.res, mon_e.due);
        end
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      tests++;
      fails++;
      $display("FAIL op%0d_timeout no done by cyc %0d, required %h at cyc %0d",
               sb[0].f, cyc, sb[0].res, sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge SYS_clk);
    #1;
  endtask

  // Issues one op and returns in its DONE cycle
  task automatic issue(input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] expv,
                       input bit inject);
    int c, lat;
    bit busy_ok;
    c   = cyc;
    lat = is_special(f, x, y) ? 2 : 35;
    MDU_start     = 1'b1;
    MDU_funct3    = f;
    MDU_operand_a = x;
    MDU_operand_b = y;
    sb.push_back('{expv, c + lat, f});
    last_exp = expv;
    busy_ok  = 1'b1;
    tick();
    MDU_start     = 1'b0;
    MDU_operand_a = $urandom;
    MDU_operand_b = $urandom;
    MDU_funct3    = 3'($urandom);
    while (cyc < c + lat) begin
      if (MDU_busy !== 1'b1) busy_ok = 1'b0;
      if (inject && cyc == c + 10) begin
        MDU_start     = 1'b1;
        MDU_operand_a = $urandom;
        MDU_operand_b = $urandom;
      end
      tick();
      MDU_start = 1'b0;
    end
    tests++;
    if (!busy_ok || MDU_busy !== 1'b0) begin
      fails++;
      $display("FAIL op%0d_busy window got busy_ok=%0d busy_at_done=%b, required 1 and 0",
               f, busy_ok, MDU_busy);
    end
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, r;
  } vec_t;

  vec_t dir[12];

  initial begin
    dir[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    dir[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    dir[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    dir[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    dir[4]  = '{3'd5, 32'd100, 32'd7, 32'd14};
    dir[5]  = '{3'd7, 32'd100, 32'd7, 32'd2};
    dir[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
    dir[7]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
    dir[8]  = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF};
    dir[9]  = '{3'd7, 32'd5, 32'd0, 32'd5};
    dir[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    dir[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

    SYS_reset     = 1'b1;
    MDU_start     = 1'b0;
    MDU_funct3    = '0;
    MDU_operand_a = '0;
    MDU_operand_b = '0;
    last_exp      = '0;
    repeat (3) tick();
    tests++;
    if (MDU_busy !== 1'b0 || MDU_done !== 1'b0 || MDU_result !== 32'd0) begin
      fails++;
      $display("FAIL reset_state got busy=%b done=%b result=%h, required 0 0 0",
               MDU_busy, MDU_done, MDU_result);
    end
    SYS_reset = 1'b0;
    tick();

    foreach (dir[i]) begin
      issue(dir[i].f, dir[i].a, dir[i].b, dir[i].r, 1'b0);
      tick();
    end

    // Start pulse during CALC must be ignored
    issue(3'd5, 32'd1000, 32'd3, 32'd333, 1'b1);
    tick();

    // Back-to-back: second start in the DONE cycle
    issue(3'd4, 32'hFFFF_FF9C, 32'd9, ref_mdu(3'd4, 32'hFFFF_FF9C, 32'd9), 1'b0);
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0,
          ref_mdu(3'd0, 32'h1234_5678, 32'h9ABC_DEF0), 1'b0);
    issue(3'd6, 32'd7, 32'd0, 32'd7, 1'b0);
    tick();
    tests++;
    if (MDU_result !== 32'd7) begin
      fails++;
      $display("FAIL result_hold got %h, required %h", MDU_result, 32'd7);
    end

    // Reset mid-divide aborts without a done pulse
    begin
      int c;
      c = cyc;
      MDU_start     = 1'b1;
      MDU_funct3    = 3'd4;
      MDU_operand_a = 32'd1000;
      MDU_operand_b = 32'd3;
      tick();
      MDU_start = 1'b0;
      while (cyc < c + 10) tick();
      SYS_reset = 1'b1;
      tick();
      SYS_reset = 1'b0;
      tests++;
      if (MDU_busy !== 1'b0 || MDU_result !== 32'd0) begin
        fails++;
        $display("FAIL reset_abort got busy=%b result=%h, required 0 00000000",
                 MDU_busy, MDU_result);
      end
      repeat (40) tick();
    end

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f;
      logic [31:0] x, y;
      f = 3'($urandom);
      x = pick();
      y = pick();
      issue(f, x, y, ref_mdu(f, x, y), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        repeat ($urandom_range(0, 2)) tick();
        tests++;
        if (MDU_result !== last_exp) begin
          fails++;
          $display("FAIL result_hold got %h, required %h", MDU_result, last_exp);
        end
      end
    end

    repeat (40) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
